// File: rtl/button_conditioner_pkg.sv
// Shared constants for the front-panel button conditioner: channel indices,
// repeat FSM encoding and a counter sizing helper.
package button_conditioner_pkg;

    localparam int NUM_BTN     = 6;

    localparam int BTN_ARRIBA  = 0;
    localparam int BTN_ABAJO   = 1;
    localparam int BTN_DERECHA = 2;
    localparam int BTN_IZQDA   = 3;
    localparam int BTN_CENTRO  = 4;
    localparam int BTN_ALSTOP  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the panel pins and the menu FSM: raw lines in,
// clean levels and press pulses out.
interface button_conditioner_if
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN = NUM_BTN
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic             any_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output any_press
    );
endinterface

// File: rtl/button_conditioner_channel.sv
// One button lane: 2-flop synchroniser, restartable debounce window,
// rising-edge press pulse and optional auto-repeat FSM.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter bit RPT_EN       = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(max3(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1;

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] db_cnt_r;
    logic          press_r;
    rpt_state_t    state_r;
    logic [CW-1:0] rpt_cnt_r;

    logic          db_hit_s;
    logic          level_nxt_s;
    logic          rise_s;
    logic [CW-1:0] db_cnt_nxt_s;
    rpt_state_t    state_nxt_s;
    logic [CW-1:0] rpt_cnt_nxt_s;
    logic          rpt_pulse_s;
    logic          press_nxt_s;

    // Debounce: any return of synced to the stable value restarts the window.
    always_comb begin
        db_hit_s     = 1'b0;
        level_nxt_s  = stable_r;
        db_cnt_nxt_s = {CW{1'b0}};
        if (sync2_r != stable_r) begin
            if (db_cnt_r == CW'(DB_CYCLES - 1)) begin
                db_hit_s     = 1'b1;
                level_nxt_s  = sync2_r;
                db_cnt_nxt_s = {CW{1'b0}};
            end else begin
                db_cnt_nxt_s = db_cnt_r + CW'(1);
            end
        end else begin
            db_cnt_nxt_s = {CW{1'b0}};
        end
        rise_s = db_hit_s & sync2_r;
    end

    // Repeat FSM; judged on the level being committed this edge so a pulse
    // never coincides with a low level.
    always_comb begin
        state_nxt_s   = state_r;
        rpt_cnt_nxt_s = rpt_cnt_r;
        rpt_pulse_s   = 1'b0;
        if (!RPT_EN || !level_nxt_s) begin
            state_nxt_s   = IDLE;
            rpt_cnt_nxt_s = {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_nxt_s   = DELAY;
                        rpt_cnt_nxt_s = {CW{1'b0}};
                    end else begin
                        state_nxt_s   = IDLE;
                    end
                end
                DELAY: begin
                    if (rpt_cnt_r == CW'(REPEAT_DELAY - 1)) begin
                        rpt_pulse_s   = 1'b1;
                        state_nxt_s   = REPEAT;
                        rpt_cnt_nxt_s = {CW{1'b0}};
                    end else begin
                        rpt_cnt_nxt_s = rpt_cnt_r + CW'(1);
                    end
                end
                REPEAT: begin
                    if (rpt_cnt_r == CW'(REPEAT_RATE - 1)) begin
                        rpt_pulse_s   = 1'b1;
                        rpt_cnt_nxt_s = {CW{1'b0}};
                    end else begin
                        rpt_cnt_nxt_s = rpt_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_nxt_s   = IDLE;
                    rpt_cnt_nxt_s = {CW{1'b0}};
                end
            endcase
        end
        press_nxt_s = rise_s | rpt_pulse_s;
    end

    // State registers for sync chain, debounce, FSM and the press output.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            stable_r  <= 1'b0;
            db_cnt_r  <= {CW{1'b0}};
            press_r   <= 1'b0;
            state_r   <= IDLE;
            rpt_cnt_r <= {CW{1'b0}};
        end else begin
            sync1_r   <= raw;
            sync2_r   <= sync1_r;
            stable_r  <= level_nxt_s;
            db_cnt_r  <= db_cnt_nxt_s;
            press_r   <= press_nxt_s;
            state_r   <= state_nxt_s;
            rpt_cnt_r <= rpt_cnt_nxt_s;
        end
    end

    assign level = stable_r;
    assign press = press_r;

endmodule

// File: rtl/button_conditioner.sv
// Front-panel input stage: N_BTN independent conditioned channels plus an
// any-press summary for the menu FSM.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int               N_BTN        = NUM_BTN,
    parameter int               DB_CYCLES    = 1000000,
    parameter int               REPEAT_DELAY = 50000000,
    parameter int               REPEAT_RATE  = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = 6'b000011
) (
    input  logic                 CLK,
    input  logic                 RST,
    button_conditioner_if.slave  bus
);
    logic [N_BTN-1:0] level_s;
    logic [N_BTN-1:0] press_s;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .RPT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .CLK   (CLK),
            .RST   (RST),
            .raw   (bus.btn_raw[i]),
            .level (level_s[i]),
            .press (press_s[i])
        );
    end

    assign bus.btn_level = level_s;
    assign bus.btn_press = press_s;
    // Same-cycle summary, no arbitration between channels.
    assign bus.any_press = |press_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed plus randomized stimulus checked every cycle against a
// time-window reference model of the button conditioner.
module tb_button_conditioner;
    localparam int              NB   = 6;
    localparam int              DB   = 4;
    localparam int              RD   = 20;
    localparam int              RR   = 5;
    localparam logic [NB-1:0]   MASK = 6'b000011;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    button_conditioner_if #(.N_BTN(NB)) bus ();

    button_conditioner #(
        .N_BTN        (NB),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .REPEAT_MASK  (MASK)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model: raw samples newest-first; a level flips once the DB samples that
    // have crossed the 2-flop chain agree and differ from it.
    logic [NB-1:0] hist [0:DB+1];
    logic [NB-1:0] m_lvl;
    logic [NB-1:0] m_press;
    int            since [NB];
    logic [NB-1:0] raw_v;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= DB + 1; k++) hist[k] = '0;
        m_lvl   = '0;
        m_press = '0;
        for (int i = 0; i < NB; i++) since[i] = -1;
    endtask

    task automatic model_edge();
        logic prev, v, agree, rose;
        for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = raw_v;
        for (int i = 0; i < NB; i++) begin
            prev  = m_lvl[i];
            v     = hist[2][i];
            agree = 1'b1;
            for (int k = 2; k <= DB + 1; k++) if (hist[k][i] !== v) agree = 1'b0;
            if (agree && v !== prev) m_lvl[i] = v;
            rose = m_lvl[i] & ~prev;
            if (rose) since[i] = 0;
            else if (m_lvl[i]) since[i] = since[i] + 1;
            else since[i] = -1;
            m_press[i] = rose | (MASK[i] & m_lvl[i] & (since[i] >= RD) &&
                                 ((since[i] - RD) % RR == 0));
        end
    endtask

    task automatic cyc(input logic [NB-1:0] r);
        bus.btn_raw = r;
        raw_v       = r;
        @(posedge CLK);
        if (RST) model_edge();
        else model_reset();
        #1;
        check("level", bus.btn_level, m_lvl);
        check("press", bus.btn_press, m_press);
        check("any_press", {5'b0, bus.any_press}, {5'b0, |m_press});
    endtask

    task automatic hold(input logic [NB-1:0] r, input int n);
        for (int c = 0; c < n; c++) cyc(r);
    endtask

    initial begin
        logic [31:0] rnd;
        bus.btn_raw = '0;
        raw_v       = '0;
        model_reset();

        // Reset state
        #12;
        check("reset_level", bus.btn_level, 6'b000000);
        check("reset_press", bus.btn_press, 6'b000000);
        check("reset_any", {5'b0, bus.any_press}, 6'b000000);
        RST = 1'b1;
        hold(6'b000000, 5);

        // Clean press on centro (no repeat)
        hold(6'b010000, 30);
        hold(6'b000000, 12);

        // Bouncing derecha: 2-cycle runs then a steady hold
        hold(6'b000100, 2); hold(6'b000000, 2);
        hold(6'b000100, 2); hold(6'b000000, 2);
        hold(6'b000100, 14);
        hold(6'b000000, 12);

        // Auto-repeat on arriba held well past the press pulse
        hold(6'b000001, 68);
        hold(6'b000000, 20);

        // Abajo released inside the repeat delay
        hold(6'b000010, 16);
        hold(6'b000000, 30);

        // Simultaneous arriba + izquierda
        hold(6'b001001, 10);
        hold(6'b000000, 12);

        // Async reset mid-repeat, then release with arriba held
        hold(6'b000001, 33);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_level", bus.btn_level, 6'b000000);
        check("async_rst_press", bus.btn_press, 6'b000000);
        check("async_rst_any", {5'b0, bus.any_press}, 6'b000000);
        model_reset();
        hold(6'b000001, 3);
        RST = 1'b1;
        hold(6'b000001, 40);
        hold(6'b000000, 15);

        // Randomized runs including short glitches
        for (int n = 0; n < 60; n++) begin
            rnd = $urandom;
            hold(rnd[NB-1:0], int'($urandom_range(1, 35)));
        end
        hold(6'b000000, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-panel input stage directly upstream of the menu/control FSM.
- Takes raw asynchronous push-button lines (arriba, abajo, derecha, izquierda, centro, alarma_stop), then synchronises, debounces and edge-detects each one.
- Emits clean levels and single-cycle press pulses. Up/down get auto-repeat so held buttons step time/date fields.
- All channels are independent; one clock domain.

Parameters:
- N_BTN, 6, number of button channels.
- DB_CYCLES, 1000000, cycles a synchronised input must stay at its new value before it is accepted (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000, cycles from press pulse to first repeat pulse.
- REPEAT_RATE, 10000000, cycles between subsequent repeat pulses.
- REPEAT_MASK, 6'b000011, per-channel auto-repeat enable (bit0 arriba, bit1 abajo).

Ports:
- CLK  input  1  system clock
- RST  input  1  reset; asynchronous, active-low
- btn_raw  input  N_BTN  raw buttons, active-high. Index map: 0 arriba, 1 abajo, 2 derecha, 3 izquierda, 4 centro, 5 alarma_stop.
- btn_level  output  N_BTN  debounced level per channel
- btn_press  output  N_BTN  one-cycle pulse per accepted press and per auto-repeat step
- any_press  output  1  OR of btn_press, same cycle

Behaviour:
- Reset (RST=0, async): sync flops, debounce counters, stable levels, repeat counters and FSMs clear. btn_level=0, btn_press=0, any_press=0. All outputs are registered except any_press, which is a combinational OR of registered btn_press.
- Synchroniser: 2-flop chain per channel, reset to 0.
- Debounce, per channel:
  - Counter advances while synced != stable and clears whenever synced == stable, so any bounce restarts the window.
  - When the counter reaches DB_CYCLES-1 with synced still differing: stable <= synced and the counter clears.
  - Latency: a clean raw edge gives a btn_level change exactly DB_CYCLES+2 clock edges after the first edge that samples the new raw value.
- Press pulse: btn_press[i]=1 for exactly one cycle, in the first cycle btn_level[i] reads 1. Release produces no pulse.
- Repeat FSM, per channel, active only if REPEAT_MASK[i]=1; otherwise held in IDLE.
  - IDLE: on press, go to DELAY and clear the counter.
  - DELAY: count. When the counter reaches REPEAT_DELAY-1, pulse btn_press, go to REPEAT and clear the counter. The first repeat pulse therefore lands REPEAT_DELAY cycles after the press pulse.
  - REPEAT: count. When the counter reaches REPEAT_RATE-1, pulse and clear. Pulses are spaced exactly REPEAT_RATE cycles.
  - Any state: btn_level=0 returns the FSM to IDLE with the counter cleared in the same cycle. No pulse is emitted on that cycle.
- Counter width: $clog2(max(DB_CYCLES,REPEAT_DELAY,REPEAT_RATE))+1. Counters never wrap; they clear at the terminal count.
- Parameters must be >=1. DB_CYCLES=1 means a change is accepted on the first synced mismatch.
- Simultaneous events: channels are fully independent. Multiple btn_press bits may assert in the same cycle; no priority is applied here (arbitration belongs to the menu FSM).
- A button held through reset release is seen as a new press: btn_level rises and btn_press fires DB_CYCLES+2 cycles after RST deasserts.
- Reset asserted mid-debounce or mid-repeat aborts immediately. No pulse is emitted during or on exit of reset.
- Glitches shorter than DB_CYCLES are never visible on any output.

Decomposition:
- Shared package holds:
  - button index constants (BTN_ARRIBA=0 … BTN_ALSTOP=5);
  - repeat FSM state encoding: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2.
- Natural sub-module: button_channel. It contains sync, debounce, edge detect and the repeat FSM, with its repeat enable as a parameter. button_conditioner instantiates it N_BTN times via generate and forms any_press.

Test Plan (bench params DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5):
- Clean press, centro:
  - btn_raw[4] 0->1 held 30 cycles -> btn_level[4] rises 6 edges later.
  - btn_press[4] is high for exactly 1 cycle, with any_press in the same cycle.
  - No repeats, since mask bit 4 = 0.
- Bounce, derecha: raw toggles 1,0,1,0 with 2-cycle runs, then holds 1 -> btn_level[2] rises 6 edges after the final 0->1 edge; exactly one btn_press[2].
- Auto-repeat, arriba: hold btn_raw[0] 60 cycles past the press pulse at cycle P -> btn_press[0] pulses at P, P+20, P+25, P+30, …, P+60, then stops.
- Release mid-DELAY, abajo: release at P+10 -> btn_level[1] falls 6 edges later; no pulse at P+20; the FSM is back in IDLE.
- Simultaneous press of arriba and izquierda on the same edge -> btn_press[0] and btn_press[3] assert in the same cycle; any_press is 1 for one cycle.
- Reset handling:
  - RST=0 asserted mid-REPEAT -> all outputs 0 immediately.
  - Release RST with arriba still held -> btn_press[0] fires 6 cycles after release, then repeats resume at +20.
